// File: rtl/branch_predictor_if.sv
// Fetch/execute-side connection bundle for the branch predictor.
// The master drives fetch PC and resolved branch info; the slave returns predictions, redirects and counters.
interface branch_predictor_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] pc_f;
   logic                  predict_taken_f;
   logic [DATA_WIDTH-1:0] predict_target_f;
   logic                  valid_e;
   logic                  branch_e;
   logic                  jump_e;
   logic                  taken_e;
   logic [DATA_WIDTH-1:0] pc_e;
   logic [DATA_WIDTH-1:0] target_e;
   logic                  predicted_e;
   logic [DATA_WIDTH-1:0] predicted_target_e;
   logic                  mispredict_e;
   logic [DATA_WIDTH-1:0] redirect_pc_e;
   logic                  flush_d;
   logic                  flush_e;
   logic [31:0]           branch_count;
   logic [31:0]           mispredict_count;

   modport master (
      output pc_f, valid_e, branch_e, jump_e, taken_e, pc_e, target_e,
             predicted_e, predicted_target_e,
      input  predict_taken_f, predict_target_f, mispredict_e, redirect_pc_e,
             flush_d, flush_e, branch_count, mispredict_count
   );

   modport slave (
      input  pc_f, valid_e, branch_e, jump_e, taken_e, pc_e, target_e,
             predicted_e, predicted_target_e,
      output predict_taken_f, predict_target_f, mispredict_e, redirect_pc_e,
             flush_d, flush_e, branch_count, mispredict_count
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency fetch lookup,
// execute-stage mispredict detection/redirect, and saturating event counters.
module branch_predictor #(
   parameter int ENTRIES    = 16,
   parameter int DATA_WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   branch_predictor_if.slave bp
);
   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = DATA_WIDTH - IDX - 2;

   logic [ENTRIES-1:0]    valid_vec;
   logic [1:0]            ctr_vec    [ENTRIES];
   logic [TAG_W-1:0]      tag_reg    [ENTRIES];
   logic [DATA_WIDTH-1:0] target_reg [ENTRIES];
   logic                  jmp_reg    [ENTRIES];

   logic [31:0] branch_count_reg;
   logic [31:0] mispredict_count_reg;

   // ---------------- fetch lookup ----------------
   logic [IDX-1:0]   idx_f;
   logic [TAG_W-1:0] tag_f;
   logic             hit_f;
   logic             taken_f;

   assign idx_f   = bp.pc_f[IDX+1:2];
   assign tag_f   = bp.pc_f[DATA_WIDTH-1:IDX+2];
   assign hit_f   = valid_vec[idx_f] && (tag_reg[idx_f] == tag_f);
   assign taken_f = hit_f && (jmp_reg[idx_f] || ctr_vec[idx_f][1]);

   assign bp.predict_taken_f  = taken_f;
   assign bp.predict_target_f = taken_f ? target_reg[idx_f] : '0;

   // ---------------- execute resolution ----------------
   logic [IDX-1:0]   idx_e;
   logic [TAG_W-1:0] tag_e;
   logic             hit_e;
   logic             res;
   logic             alias_e;
   logic             mispredict;
   logic             upd_inc;
   logic             upd_dec;
   logic             alloc;

   assign idx_e   = bp.pc_e[IDX+1:2];
   assign tag_e   = bp.pc_e[DATA_WIDTH-1:IDX+2];
   assign hit_e   = valid_vec[idx_e] && (tag_reg[idx_e] == tag_e);
   assign res     = bp.valid_e && (bp.branch_e || bp.jump_e);
   // A prediction made for something that turned out not to be a branch means the entry aliased.
   assign alias_e = bp.valid_e && !bp.branch_e && !bp.jump_e && bp.predicted_e;

   assign mispredict = (res && ((bp.taken_e != bp.predicted_e) ||
                                (bp.taken_e && (bp.target_e != bp.predicted_target_e))))
                       || alias_e;

   assign upd_inc = res && hit_e && bp.taken_e;
   assign upd_dec = res && hit_e && !bp.taken_e;
   assign alloc   = res && !hit_e && bp.taken_e;

   assign bp.mispredict_e  = mispredict;
   assign bp.redirect_pc_e = (res && bp.taken_e) ? bp.target_e
                                                 : bp.pc_e + DATA_WIDTH'(4);
   assign bp.flush_d       = mispredict;
   assign bp.flush_e       = mispredict;

   // ---------------- per-entry valid and direction state ----------------
   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic       valid_reg;
         logic [1:0] ctr_reg;
         logic       sel;

         assign sel = (idx_e == IDX'(gi));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_reg <= 1'b0;
               ctr_reg   <= 2'b00;
            end else if (sel) begin
               if (alloc) begin
                  valid_reg <= 1'b1;
                  ctr_reg   <= 2'b10;
               end else if (upd_inc) begin
                  ctr_reg <= (ctr_reg == 2'b11) ? 2'b11 : ctr_reg + 2'b01;
               end else if (upd_dec) begin
                  ctr_reg <= (ctr_reg == 2'b00) ? 2'b00 : ctr_reg - 2'b01;
               end else if (alias_e) begin
                  valid_reg <= 1'b0;
               end
            end
         end

         assign valid_vec[gi] = valid_reg;
         assign ctr_vec[gi]   = ctr_reg;
      end
   endgenerate

   // Tag/target/jmp are qualified by valid, so they need no reset; writes are still held off during reset.
   always_ff @(posedge clk) begin
      if (!rst && (alloc || upd_inc)) begin
         tag_reg[idx_e]    <= tag_e;
         target_reg[idx_e] <= bp.target_e;
         jmp_reg[idx_e]    <= bp.jump_e;
      end
   end

   // ---------------- performance counters ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_count_reg     <= '0;
         mispredict_count_reg <= '0;
      end else begin
         if (res && (branch_count_reg != 32'hFFFF_FFFF))
            branch_count_reg <= branch_count_reg + 32'd1;
         if (mispredict && (mispredict_count_reg != 32'hFFFF_FFFF))
            mispredict_count_reg <= mispredict_count_reg + 32'd1;
      end
   end

   assign bp.branch_count     = branch_count_reg;
   assign bp.mispredict_count = mispredict_count_reg;

   logic unused_pc_bits;
   assign unused_pc_bits = ^bp.pc_f[1:0];
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch target buffer with 2-bit saturating direction counters, updated at branch resolution in execute. It predicts next-PC in fetch, detects mispredictions from the execute-stage branch outcome (`PCSrc` from the branch resolver), and drives the redirect PC and the decode/execute flushes. It also keeps saturating branch and mispredict performance counters.

## Interface
- `ENTRIES`, 16, number of BTB entries (power of two, ≥2); `IDX = log2(ENTRIES)`
- `DATA_WIDTH`, 32, PC/target width
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `pc_f` in DATA_WIDTH: fetch PC, word aligned
- `predict_taken_f` out 1: fetch should take `predict_target_f`
- `predict_target_f` out DATA_WIDTH: predicted target (0 when not taken)
- `valid_e` in 1: execute holds a real instruction, not a bubble or stalled copy
- `branch_e` in 1: conditional branch (branch op ≠ NONE)
- `jump_e` in 1: JAL/JALR
- `taken_e` in 1: resolved outcome (`PCSrc`)
- `pc_e` in DATA_WIDTH: PC of the execute instruction
- `target_e` in DATA_WIDTH: resolved target
- `predicted_e` in 1, `predicted_target_e` in DATA_WIDTH: fetch prediction, piped to execute
- `mispredict_e` out 1: redirect required this cycle
- `redirect_pc_e` out DATA_WIDTH: correct next PC
- `flush_d` out 1, `flush_e` out 1: squash decode/execute registers at next edge
- `branch_count` out 32, `mispredict_count` out 32: saturating event counters

## Operation
- Entry fields: `valid`, `tag = pc[DATA_WIDTH-1:IDX+2]`, `target`, `jmp`, `ctr[1:0]`. Index = `pc[IDX+1:2]`.
- Lookup is combinational on `pc_f`. Hit = `valid && tag match`. `predict_taken_f = hit && (jmp || ctr[1])`. `predict_target_f = target` when taken, else 0.
- Resolution is combinational. Let `res = valid_e && (branch_e || jump_e)`.
  - Mispredict when `res && (taken_e != predicted_e || (taken_e && target_e != predicted_target_e))`.
  - Alias case: `valid_e && !branch_e && !jump_e && predicted_e` is also a mispredict.
- `redirect_pc_e` is `target_e` if `res && taken_e`, else `pc_e + 4`. It is valid only while `mispredict_e` is high; otherwise it still follows the same formula.
- `flush_d = flush_e = mispredict_e`.
- Table update at the clock edge, indexed by `pc_e`:
  - `res` and hit, taken: `ctr` increments, saturating at 3; `target <= target_e`; `jmp <= jump_e`.
  - `res` and hit, not taken: `ctr` decrements, saturating at 0; target is unchanged.
  - `res` and miss, taken: allocate and overwrite the slot. Set valid, write the tag, `target_e` and `jmp = jump_e`, and set `ctr = 2'b10`.
  - `res` and miss, not taken: no change.
  - Alias case: clear `valid` at the `pc_e` index.
- Counters:
  - `branch_count` increments on `res`.
  - `mispredict_count` increments on `mispredict_e`.
  - Both saturate at 0xFFFFFFFF.

## Timing
- Prediction has zero latency. An update written at edge N is visible to lookups from cycle N+1 onward.
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents. There is no bypass.
- `mispredict_e`, `redirect_pc_e` and the flushes are combinational in the resolve cycle. The pipeline registers consume them at the next edge.
- When `valid_e` = 0, no update, no count and no mispredict occur, whatever the other execute inputs are.
- Reset (asynchronous, any cycle, including mid-update):
  - All `valid` bits and `ctr` fields go to 0, and both counters go to 0.
  - `predict_taken_f` = 0 and `predict_target_f` = 0 immediately.
  - `mispredict_e` follows its inputs.
  - No update takes effect on an edge while `rst` is high.
- Index wrap-around: PCs differing only above bit IDX+1 share a slot. The tag mismatch gives a miss, and allocation evicts the old entry.

## Test plan
- Reset, then `pc_f`=0x100 → `predict_taken_f`=0, target 0, both counters 0.
- Branch at 0x100, taken to 0x80, `predicted_e`=0:
  - Expect `mispredict_e`=1, `redirect_pc_e`=0x80, flushes high.
  - Next cycle `pc_f`=0x100 → taken, target 0x80, `ctr`=2.
- Resolve the 0x100 branch taken 3 times, then not taken once:
  - `ctr` saturates at 3, then goes to 2, and the prediction stays taken.
  - The not-taken resolve with `predicted_e`=1 gives a mispredict, `redirect_pc_e`=0x104.
- With ENTRIES=16, allocate 0x100 taken, then 0x140 taken (same index):
  - `pc_f`=0x100 now misses.
  - `pc_f`=0x140 hits with the new target.
- JAL at 0x200 to 0x400 allocated, then resolved with `predicted_e`=1 and `predicted_target_e`=0x400 → no mispredict; `branch_count` increments.
- Non-branch at 0x100 with `predicted_e`=1 → mispredict, `redirect_pc_e`=0x104, and entry 0x100 invalid the next cycle. Assert `rst` mid-sequence → all outputs clear asynchronously.
